// File: rtl/pe_xbar_cfg_seq.sv
// Crossbar switch-context sequencer: stores CTX_DEPTH switch words and replays
// contexts 0..ctx_last for loop_num passes. Optional selector check: PE_XBAR_SEL_CHECK_EN.
module pe_xbar_cfg_seq #(
  parameter int unsigned CTX_DEPTH = 8,
  parameter int unsigned CTX_AW    = 3,
  parameter int unsigned SW_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CTX_AW-1:0] cfg_addr,
  input  logic [SW_W-1:0]   cfg_data,
  input  logic [CTX_AW-1:0] ctx_last,
  input  logic [7:0]        loop_num,
  input  logic              start,
  input  logic              stall,
  output logic [SW_W-1:0]   switch,
  output logic [CTX_AW-1:0] ctx_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LOOP_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_d;
  logic [SW_W-1:0]     ctx_mem [CTX_DEPTH];
  logic [CTX_AW-1:0]   last_q, last_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic [LOOP_W-1:0]   pass_q, pass_d;
  logic [SW_W-1:0]     switch_d;
  logic [CTX_AW-1:0]   idx_d;
  logic [CTX_AW-1:0]   idx_inc;
  logic                busy_d, done_d, err_d;
  logic                wr_en;
  logic                sel_ok;

`ifdef PE_XBAR_SEL_CHECK_EN
  localparam int unsigned NSEL = SW_W / 3;

  // Every 3-bit selector must name N, S, W, E or LSU (codes 0..4).
  function automatic logic sel_legal(input logic [SW_W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(NSEL); i++) begin
      if (w[3*i +: 3] > 3'd4) ok = 1'b0;
    end
    return ok;
  endfunction

  assign sel_ok = sel_legal(cfg_data);
`else
  assign sel_ok = 1'b1;
`endif

  assign idx_inc = CTX_AW'(ctx_idx + 1'b1);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    switch_d = switch;
    idx_d    = ctx_idx;
    pass_d   = pass_q;
    last_d   = last_q;
    loop_d   = loop_q;
    busy_d   = busy;
    done_d   = 1'b0;
    err_d    = err;
    wr_en    = 1'b0;
    case (state)
      IDLE: begin
        switch_d = '0;
        idx_d    = '0;
        busy_d   = 1'b0;
        if (start) begin
          state_d  = RUN;
          last_d   = ctx_last;
          loop_d   = (loop_num == 8'd0) ? 8'd0 : LOOP_W'(loop_num - 8'd1);
          pass_d   = '0;
          switch_d = ctx_mem[0];
          busy_d   = 1'b1;
          err_d    = 1'b0;
        end
        // A rejected write in the same cycle as start still flags err.
        if (cfg_we) begin
          if (sel_ok) wr_en = 1'b1;
          else        err_d = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (ctx_idx != last_q) begin
            idx_d    = idx_inc;
            switch_d = ctx_mem[idx_inc];
          end else if (pass_q != loop_q) begin
            idx_d    = '0;
            switch_d = ctx_mem[0];
            pass_d   = LOOP_W'(pass_q + 8'd1);
          end else begin
            state_d  = DONE;
            idx_d    = '0;
            switch_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        switch_d = '0;
        idx_d    = '0;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        switch_d = '0;
        idx_d    = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      switch  <= '0;
      ctx_idx <= '0;
      pass_q  <= '0;
      last_q  <= '0;
      loop_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      switch  <= switch_d;
      ctx_idx <= idx_d;
      pass_q  <= pass_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // Context storage survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) ctx_mem[cfg_addr] <= cfg_data;
  end

endmodule

// File: tb/tb_pe_xbar_cfg_seq.sv
// Randomised bench for pe_xbar_cfg_seq against a queue-based playback model,
// plus literal sequence checks for the directed scenarios.
module tb_pe_xbar_cfg_seq;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic [2:0]  ctx_last;
  logic [7:0]  loop_num;
  logic        start;
  logic        stall;
  logic [11:0] switch;
  logic [2:0]  ctx_idx;
  logic        busy;
  logic        done;
  logic        err;

  pe_xbar_cfg_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ctx_last(ctx_last), .loop_num(loop_num),
    .start(start), .stall(stall), .switch(switch), .ctx_idx(ctx_idx),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [11:0] sw;
  } ent_t;

  // Model: memory image, queue of contexts still to be shown, done/err flags.
  logic [11:0] mmem [8];
  ent_t        mq [$];
  bit          mdone;
  bit          merr;

  int          checks;
  int          failures;
  logic [11:0] sw_log [$];
  logic [11:0] exp_q [$];
  int          busy_n;
  int          done_n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic bit legal(input logic [11:0] w);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) if (w[3*k +: 3] > 3'd4) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_update();
    ent_t e;
    int   lp;
    if (!rst_n) begin
      mq.delete();
      mdone = 1'b0;
      merr  = 1'b0;
    end else if (mq.size() != 0) begin
      if (!stall) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mdone = 1'b1;
      end
    end else if (mdone) begin
      mdone = 1'b0;
    end else begin
      if (start) begin
        lp = (loop_num == 8'd0) ? 1 : int'(loop_num);
        for (int p = 0; p < lp; p++)
          for (int i = 0; i <= int'(ctx_last); i++) begin
            e.idx = 3'(i);
            e.sw  = mmem[i];
            mq.push_back(e);
          end
        merr = 1'b0;
      end
      if (cfg_we) begin
`ifdef PE_XBAR_SEL_CHECK_EN
        if (legal(cfg_data)) mmem[cfg_addr] = cfg_data;
        else                 merr = 1'b1;
`else
        mmem[cfg_addr] = cfg_data;
`endif
      end
    end
  endtask

  task automatic compare_all();
    bit          act;
    logic [11:0] esw;
    logic [2:0]  eidx;
    act  = (mq.size() != 0);
    esw  = act ? mq[0].sw : 12'h000;
    eidx = act ? mq[0].idx : 3'd0;
    check("switch", 32'(switch), 32'(esw));
    check("ctx_idx", 32'(ctx_idx), 32'(eidx));
    check("busy", 32'(busy), 32'(act));
    check("done", 32'(done), 32'(mdone));
    check("err", 32'(err), 32'(merr));
    if (busy) begin
      sw_log.push_back(switch);
      busy_n++;
    end
    if (done) done_n++;
  endtask

  // Inputs change only at negedge; model follows each posedge; compare at negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clear_log();
    sw_log.delete(); busy_n = 0; done_n = 0;
  endtask

  task automatic do_run(input int last, input int loops, input int stall_idx,
                        input bit we_mid, input bit rnd);
    int budget;
    bit stalled;
    clear_log();
    ctx_last = 3'(last); loop_num = 8'(loops); start = 1'b1;
    tick();
    start = 1'b0;
    if (rnd) begin
      ctx_last = 3'($urandom); loop_num = 8'($urandom);
    end
    budget = 0; stalled = 1'b0;
    while (!mdone && budget < 3000) begin
      stall = 1'b0;
      if (stall_idx >= 0 && !stalled && mq.size() != 0 && int'(mq[0].idx) == stall_idx) begin
        stall = 1'b1; stalled = 1'b1;
      end
      if (rnd) begin
        stall    = ($urandom_range(3) == 0);
        start    = ($urandom_range(5) == 0);
        cfg_we   = ($urandom_range(3) == 0);
        cfg_addr = 3'($urandom);
        cfg_data = 12'($urandom);
      end else if (we_mid) begin
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 12'h777;
      end
      tick();
      budget++;
    end
    start = 1'b0; cfg_we = 1'b0; stall = 1'b0;
    if (!mdone) begin
      checks++; failures++;
      $display("FAIL run_timeout act=busy_after_%0d_cycles exp=done", budget);
    end
    tick();
  endtask

  task automatic check_seq(input string nm);
    check({nm, "_len"}, 32'(sw_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sw_log.size(); i++)
      check($sformatf("%s_%0d", nm, i), 32'(sw_log[i]), 32'(exp_q[i]));
  endtask

  function automatic logic [11:0] rnd_word();
    logic [11:0] w;
    for (int k = 0; k < 4; k++) w[3*k +: 3] = 3'($urandom_range(0, 5));
    return w;
  endfunction

  initial begin
    checks = 0; failures = 0; mdone = 1'b0; merr = 1'b0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    ctx_last = '0; loop_num = '0; start = 1'b0; stall = 1'b0;
    clear_log();
    tick(); tick();
    check("rst_switch", 32'(switch), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    tick();

    wr(0, 12'h001); wr(1, 12'h04A); wr(2, 12'h123); wr(3, 12'h0C1);
    for (int i = 4; i < 8; i++) wr(i, 12'h000);

    do_run(2, 1, -1, 1'b0, 1'b0);
    exp_q = '{12'h001, 12'h04A, 12'h123};
    check_seq("basic");
    check("basic_busy_n", 32'(busy_n), 32'd3);
    check("basic_done_n", 32'(done_n), 32'd1);

    do_run(2, 2, 1, 1'b0, 1'b0);
    exp_q = '{12'h001, 12'h04A, 12'h04A, 12'h123, 12'h001, 12'h04A, 12'h123};
    check_seq("stall");
    check("stall_busy_n", 32'(busy_n), 32'd7);

    wr(0, 12'h924);
    do_run(0, 0, -1, 1'b0, 1'b0);
    exp_q = '{12'h924};
    check_seq("loop0");
    check("loop0_done_n", 32'(done_n), 32'd1);
    wr(0, 12'h001);

    // Reset in the middle of a run.
    clear_log();
    ctx_last = 3'd2; loop_num = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_idx", 32'(ctx_idx), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_switch", 32'(switch), 32'h0);
    tick(); tick();
    check("mid_rst_done_n", 32'(done_n), 32'd0);
    do_run(2, 1, -1, 1'b0, 1'b0);
    exp_q = '{12'h001, 12'h04A, 12'h123};
    check_seq("replay");

    do_run(2, 1, -1, 1'b1, 1'b0);
    do_run(3, 1, -1, 1'b0, 1'b0);
    exp_q = '{12'h001, 12'h04A, 12'h123, 12'h0C1};
    check_seq("we_in_run");

    wr(1, 12'h005);
`ifdef PE_XBAR_SEL_CHECK_EN
    check("selchk_err", 32'(err), 32'h1);
    do_run(1, 1, -1, 1'b0, 1'b0);
    check("selchk_err_clr", 32'(err), 32'h0);
    exp_q = '{12'h001, 12'h04A};
`else
    check("selchk_err", 32'(err), 32'h0);
    do_run(1, 1, -1, 1'b0, 1'b0);
    exp_q = '{12'h001, 12'h005};
`endif
    check_seq("selchk");
    wr(1, 12'h04A);

    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        wr(int'($urandom_range(0, 7)), rnd_word());
      do_run(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), -1, 1'b0, 1'b1);
      if (it == 15) begin
        ctx_last = 3'd7; loop_num = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < int'($urandom_range(1, 10)); c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
